// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scan sequencer for a 4x4 matrix keypad. It walks a one-hot strobe across
// the columns and samples the synchronised row returns once per scan tick.
// A press is debounced before it is encoded into a 4-bit key code. The code
// is then offered downstream over a valid/ready handshake. The scan stays
// frozen on the pressed column until the release is debounced, so each
// physical press yields exactly one event.

module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 60000,   // clk cycles per scan tick, 2..65535
    parameter int DEBOUNCE_N = 3        // matching ticks to accept, 1..7
) (
    input  logic       clk,
    input  logic       reset,           // asynchronous, active-low
    input  logic [3:0] key_in,          // row returns
    output logic [3:0] key_out,         // one-hot column strobe
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       overrun
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESS    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  DB_LAST   = 3'(DEBOUNCE_N);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Bit position of a one-hot nibble. Callers only pass one-hot values.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[1]) idx = 2'd1;
        if (v[2]) idx = 2'd2;
        if (v[3]) idx = 2'd3;
        return idx;
    endfunction

    // Map {row, col} of the pressed switch to the printed key value.
    // The letters X/Y/Z and the symbols + / - / Enter take codes 10..15.
    function automatic logic [3:0] encode_key(input logic [7:0] rc);
        logic [1:0] row_idx;
        logic [1:0] col_idx;
        logic [3:0] code;
        row_idx = onehot_idx(rc[7:4]);
        col_idx = onehot_idx(rc[3:0]);
        code    = 4'd0;
        case ({row_idx, col_idx})
            4'h0: code = 4'd1;
            4'h1: code = 4'd4;
            4'h2: code = 4'd7;
            4'h3: code = 4'd0;
            4'h4: code = 4'd2;
            4'h5: code = 4'd5;
            4'h6: code = 4'd8;
            4'h7: code = 4'd13;
            4'h8: code = 4'd3;
            4'h9: code = 4'd6;
            4'hA: code = 4'd9;
            4'hB: code = 4'd14;
            4'hC: code = 4'd10;
            4'hD: code = 4'd11;
            4'hE: code = 4'd12;
            4'hF: code = 4'd15;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------
    logic [15:0] tick_cnt_reg, tick_cnt_next;
    logic        tick;

    logic [3:0]  meta_reg;
    logic [3:0]  ks_reg;

    state_t      state_reg,     state_next;
    logic [3:0]  key_out_reg,   key_out_next;
    logic [7:0]  cand_reg,      cand_next;
    logic [2:0]  db_cnt_reg,    db_cnt_next;
    logic        key_valid_reg, key_valid_next;
    logic [3:0]  key_code_reg,  key_code_next;
    logic        key_held_reg,  key_held_next;
    logic        overrun_reg,   overrun_next;

    logic [7:0]  cand_now;
    logic        ks_one_hot;
    logic [3:0]  key_out_rot;
    logic [2:0]  db_cnt_inc;
    logic        db_done;

    // ------------------------------------------------------------------
    // Scan tick generator
    // ------------------------------------------------------------------

    // Tick fires on the last count of each SCAN_DIV-cycle period.
    always_comb begin
        tick          = (tick_cnt_reg == TICK_LAST);
        tick_cnt_next = tick ? 16'd0 : tick_cnt_reg + 16'd1;
    end

    // Free-running tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_reg <= 16'd0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Row-return synchroniser
    // ------------------------------------------------------------------

    // Two-flop synchroniser on the asynchronous row returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 4'd0;
            ks_reg   <= 4'd0;
        end else begin
            meta_reg <= key_in;
            ks_reg   <= meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Decision helpers
    // ------------------------------------------------------------------

    // Candidate, one-hot test, strobe rotation and debounce count step.
    always_comb begin
        cand_now    = {ks_reg, key_out_reg};
        ks_one_hot  = (ks_reg != 4'd0) && ((ks_reg & (ks_reg - 4'd1)) == 4'd0);
        // A corrupted strobe re-enters the scan at column 0.
        if ((key_out_reg != 4'd0) &&
            ((key_out_reg & (key_out_reg - 4'd1)) == 4'd0)) begin
            key_out_rot = {key_out_reg[2:0], key_out_reg[3]};
        end else begin
            key_out_rot = 4'b0001;
        end
        db_cnt_inc  = db_cnt_reg + 3'd1;
        db_done     = (db_cnt_inc == DB_LAST);
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // Next-state and output logic; the handshake clear applies in every
    // state and a fresh press overrides it.
    always_comb begin
        state_next     = state_reg;
        key_out_next   = key_out_reg;
        cand_next      = cand_reg;
        db_cnt_next    = db_cnt_reg;
        key_code_next  = key_code_reg;
        key_held_next  = key_held_reg;
        overrun_next   = overrun_reg;
        key_valid_next = key_valid_reg & ~key_ready;

        case (state_reg)
            SCAN: begin
                if (tick) begin
                    if (ks_one_hot) begin
                        cand_next   = cand_now;
                        db_cnt_next = 3'd1;
                        state_next  = (DEBOUNCE_N == 1) ? PRESS : DEBOUNCE;
                    end else begin
                        key_out_next = key_out_rot;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (cand_now == cand_reg) begin
                        db_cnt_next = db_cnt_inc;
                        if (db_done) begin
                            state_next = PRESS;
                        end
                    end else begin
                        db_cnt_next  = 3'd0;
                        key_out_next = key_out_rot;
                        state_next   = SCAN;
                    end
                end
            end

            PRESS: begin
                key_code_next  = encode_key(cand_reg);
                key_valid_next = 1'b1;
                key_held_next  = 1'b1;
                db_cnt_next    = 3'd0;
                // An unaccepted older event is being overwritten.
                if (key_valid_reg && !key_ready) begin
                    overrun_next = 1'b1;
                end
                state_next = RELEASE;
            end

            RELEASE: begin
                if (tick) begin
                    if (ks_reg == 4'd0) begin
                        if (db_done) begin
                            key_held_next = 1'b0;
                            db_cnt_next   = 3'd0;
                            key_out_next  = key_out_rot;
                            state_next    = SCAN;
                        end else begin
                            db_cnt_next = db_cnt_inc;
                        end
                    end else begin
                        db_cnt_next = 3'd0;
                    end
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

    // State register for the sequencer and its outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= SCAN;
            key_out_reg   <= 4'b0001;
            cand_reg      <= 8'd0;
            db_cnt_reg    <= 3'd0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
            key_held_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_out_reg   <= key_out_next;
            cand_reg      <= cand_next;
            db_cnt_reg    <= db_cnt_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            key_held_reg  <= key_held_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign key_out   = key_out_reg;
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign key_held  = key_held_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4 and DEBOUNCE_N=3.
// A keypad model closes one switch (press_row/press_col) onto the strobes.
// Expected events go into a queue when a press is issued. A monitor pops
// and compares one entry each time the DUT hands over an event. Timing is
// expressed in clk edges counted from reset release; scan ticks land on
// edges 4, 8, 12, and so on.

module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE_N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_in;
    logic [3:0] key_out;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic [3:0] key_code;
    logic       key_held;
    logic       overrun;

    logic [3:0] press_row = 4'd0;
    logic [3:0] press_col = 4'd0;

    typedef struct packed {
        logic [3:0] code;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n;

    // Keypad: the closed switch returns its row only while its column is strobed.
    assign key_in = ((press_col & key_out) != 4'd0) ? press_row : 4'd0;

    keypad_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // clk edges since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0b, expected %0b", name, act, req);
    endtask

    // Wait until edge n has occurred, then settle 1 time unit.
    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (edge_n < n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                n_checks++;
                $display("FAIL wait_edge: got edge %0d, expected edge %0d", edge_n, n);
                break;
            end
        end
    endtask

    // Pull reset low, check the asynchronous clear, release after two edges.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk4("rst_key_out",   key_out,   4'b0001);
        chk1("rst_key_valid", key_valid, 1'b0);
        chk4("rst_key_code",  key_code,  4'd0);
        chk1("rst_key_held",  key_held,  1'b0);
        chk1("rst_overrun",   overrun,   1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk4("rst_release_key_out", key_out, 4'b0001);
    endtask

    // Scoreboard monitor: one compare per accepted event.
    always @(negedge clk) begin
        if (reset && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got code %0d, expected no event", key_code);
            end else begin
                mon_e = exp_q.pop_front();
                chk4("event_code",    key_code, mon_e.code);
                chk1("event_overrun", overrun,  mon_e.ovr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        do_reset();

        // 1: idle scan rotation
        wait_edge(3);  chk4("t1_col_e3",  key_out, 4'b0001);
        wait_edge(4);  chk4("t1_col_e4",  key_out, 4'b0010);
        wait_edge(7);  chk4("t1_col_e7",  key_out, 4'b0010);
        wait_edge(8);  chk4("t1_col_e8",  key_out, 4'b0100);
        wait_edge(12); chk4("t1_col_e12", key_out, 4'b1000);
        wait_edge(16); chk4("t1_col_e16", key_out, 4'b0001);
        chk1("t1_no_valid", key_valid, 1'b0);

        // 2: key 5 held five ticks, then released
        do_reset();
        press_row = 4'b0010; press_col = 4'b0010;
        exp_q.push_back('{code: 4'd5, ovr: 1'b0});
        wait_edge(16); chk1("t2_valid_e16", key_valid, 1'b0);
                       chk1("t2_held_e16",  key_held,  1'b0);
        wait_edge(17); chk1("t2_valid_e17", key_valid, 1'b1);
                       chk4("t2_code_e17",  key_code,  4'd5);
                       chk1("t2_held_e17",  key_held,  1'b1);
        wait_edge(18); chk1("t2_valid_e18", key_valid, 1'b0);
        wait_edge(24); press_row = 4'd0; press_col = 4'd0;
                       chk1("t2_held_e24",  key_held,  1'b1);
        wait_edge(35); chk1("t2_held_e35",  key_held,  1'b1);
                       chk4("t2_col_e35",   key_out,   4'b0010);
                       chk1("t2_valid_e35", key_valid, 1'b0);
        wait_edge(36); chk1("t2_held_e36",  key_held,  1'b0);
                       chk4("t2_col_e36",   key_out,   4'b0100);

        // 3: bounce on key 0, then a steady press
        do_reset();
        press_row = 4'b0001; press_col = 4'b1000;
        exp_q.push_back('{code: 4'd0, ovr: 1'b0});
        wait_edge(16); press_row = 4'd0; press_col = 4'd0;
                       chk4("t3_frozen_e16", key_out, 4'b1000);
        wait_edge(20); chk4("t3_col_e20",   key_out,   4'b0001);
                       chk1("t3_valid_e20", key_valid, 1'b0);
                       press_row = 4'b0001; press_col = 4'b1000;
        wait_edge(44); chk1("t3_valid_e44", key_valid, 1'b0);
        wait_edge(45); chk1("t3_valid_e45", key_valid, 1'b1);
                       chk4("t3_code_e45",  key_code,  4'd0);
        wait_edge(47); chk1("t3_valid_e47", key_valid, 1'b0);
        press_row = 4'd0; press_col = 4'd0;

        // 4: Enter with key_ready low, then a one-clk accept
        do_reset();
        key_ready = 1'b0;
        press_row = 4'b1000; press_col = 4'b1000;
        wait_edge(24); chk1("t4_valid_e24", key_valid, 1'b0);
        wait_edge(25); chk1("t4_valid_e25", key_valid, 1'b1);
                       chk4("t4_code_e25",  key_code,  4'd15);
        wait_edge(40); chk1("t4_valid_e40", key_valid, 1'b1);
                       chk4("t4_code_e40",  key_code,  4'd15);
                       exp_q.push_back('{code: 4'd15, ovr: 1'b0});
                       key_ready = 1'b1;
        wait_edge(41); key_ready = 1'b0;
                       chk1("t4_valid_e41", key_valid, 1'b0);
                       chk1("t4_held_e41",  key_held,  1'b1);
        press_row = 4'd0; press_col = 4'd0;
        key_ready = 1'b1;

        // 5: 7 left pending, then + overwrites it
        do_reset();
        key_ready = 1'b0;
        press_row = 4'b0001; press_col = 4'b0100;
        wait_edge(20); chk1("t5_valid_e20", key_valid, 1'b0);
        wait_edge(21); chk1("t5_valid_e21", key_valid, 1'b1);
                       chk4("t5_code_e21",  key_code,  4'd7);
                       press_row = 4'd0; press_col = 4'd0;
        wait_edge(31); chk1("t5_held_e31",  key_held,  1'b1);
        wait_edge(32); chk1("t5_held_e32",  key_held,  1'b0);
                       chk4("t5_col_e32",   key_out,   4'b1000);
                       press_row = 4'b0010; press_col = 4'b1000;
        wait_edge(44); chk4("t5_code_e44",  key_code,  4'd7);
                       chk1("t5_ovr_e44",   overrun,   1'b0);
        wait_edge(45); chk4("t5_code_e45",  key_code,  4'd13);
                       chk1("t5_ovr_e45",   overrun,   1'b1);
                       chk1("t5_valid_e45", key_valid, 1'b1);
                       exp_q.push_back('{code: 4'd13, ovr: 1'b1});
        wait_edge(46); key_ready = 1'b1;
        wait_edge(47); chk1("t5_valid_e47", key_valid, 1'b0);
                       chk1("t5_ovr_e47",   overrun,   1'b1);
        press_row = 4'd0; press_col = 4'd0;

        // 6: reset during DEBOUNCE, then during RELEASE with an event pending
        do_reset();
        press_row = 4'b0010; press_col = 4'b0010;
        wait_edge(10); chk4("t6_frozen_e10", key_out, 4'b0010);
                       press_row = 4'd0; press_col = 4'd0;
                       do_reset();
        key_ready = 1'b0;
        press_row = 4'b0010; press_col = 4'b0010;
        wait_edge(20); chk1("t6_valid_e20", key_valid, 1'b1);
                       chk1("t6_held_e20",  key_held,  1'b1);
                       press_row = 4'd0; press_col = 4'd0;
                       do_reset();
        wait_edge(20); chk1("t6_dropped_e20", key_valid, 1'b0);
                       chk4("t6_col_e20",     key_out,   4'b0010);
        key_ready = 1'b1;

        chk4("scoreboard_empty", 4'(exp_q.size()), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
